box_initiator: RTL and testbench

Bus initiator for the 4×8-bit `box` register file: accepts read/write commands on a valid/ready port, sequences the `box` strobes (`read_enable`, `write_enable`, `address`, `write_data`), and returns one response per command. It waits for `read_active` before capturing `read_data`. It sits between a controller or sequencer and a `box` instance, so `box` no longer has to be driven by hand-timed stimulus.

---
 rtl/box_initiator.sv | 160 ++++++++++++++++
 tb/tb_box_initiator.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_initiator.sv
// Valid/ready command front-end that sequences the strobes of a 4x8-bit box register file.
// Define BOX_INITIATOR_TIMEOUT_EN to fail reads that see no read_active within TIMEOUT cycles.
module box_initiator #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_error,
    output logic       busy,
    output logic       box_read_enable,
    output logic       box_write_enable,
    output logic [7:0] box_write_data,
    output logic [1:0] box_address,
    input  logic [7:0] box_read_data,
    input  logic       box_read_active
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("box_initiator: TIMEOUT must lie in 2..255");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        WAIT,
        RSP
    } state_t;

    state_t     state, state_d;
    logic       cmd_ready_d;
    logic       rsp_valid_d;
    logic [7:0] rsp_data_d;
    logic       rsp_error_d;
    logic       busy_d;
    logic       read_enable_d;
    logic       write_enable_d;
    logic [7:0] write_data_d;
    logic [1:0] address_d;

`ifdef BOX_INITIATOR_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt, cnt_d;
`endif

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_d        = state;
        rsp_valid_d    = 1'b0;
        rsp_data_d     = rsp_data;
        rsp_error_d    = rsp_error;
        read_enable_d  = 1'b0;
        write_enable_d = 1'b0;
        write_data_d   = box_write_data;
        address_d      = box_address;
`ifdef BOX_INITIATOR_TIMEOUT_EN
        cnt_d          = cnt;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    address_d = cmd_addr;
                    if (cmd_write) begin
                        write_data_d   = cmd_wdata;
                        write_enable_d = 1'b1;
                        state_d        = WR;
                    end else begin
                        read_enable_d = 1'b1;
                        state_d       = RD;
                    end
                end
            end
            WR: begin
                rsp_data_d  = box_write_data;
                rsp_error_d = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RD: begin
`ifdef BOX_INITIATOR_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (box_read_active) begin
                    rsp_data_d  = box_read_data;
                    rsp_error_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
`ifdef BOX_INITIATOR_TIMEOUT_EN
                end else if (cnt == CNT_LAST) begin
                    rsp_data_d  = 8'hFF;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt + 1'b1;
`endif
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            cmd_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_data         <= '0;
            rsp_error        <= 1'b0;
            busy             <= 1'b0;
            box_read_enable  <= 1'b0;
            box_write_enable <= 1'b0;
            box_write_data   <= '0;
            box_address      <= '0;
        end else begin
            state            <= state_d;
            cmd_ready        <= cmd_ready_d;
            rsp_valid        <= rsp_valid_d;
            rsp_data         <= rsp_data_d;
            rsp_error        <= rsp_error_d;
            busy             <= busy_d;
            box_read_enable  <= read_enable_d;
            box_write_enable <= write_enable_d;
            box_write_data   <= write_data_d;
            box_address      <= address_d;
        end
    end

`ifdef BOX_INITIATOR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_box_initiator.sv
// Directed cycle-exact bench for box_initiator, with a one-cycle-latency box model.
module tb_box_initiator;

    localparam int unsigned TO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_error, busy;
    logic [7:0] rsp_data;
    logic       box_read_enable, box_write_enable, box_read_active;
    logic [7:0] box_write_data, box_read_data;
    logic [1:0] box_address;

    logic       model_en, model_act, stray;
    logic [7:0] model_rd;
    logic [7:0] mem [4];

    int n_checks = 0;
    int n_fail   = 0;

    box_initiator #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .busy(busy),
        .box_read_enable(box_read_enable), .box_write_enable(box_write_enable),
        .box_write_data(box_write_data), .box_address(box_address),
        .box_read_data(box_read_data), .box_read_active(box_read_active)
    );

    always #5 clk = ~clk;

    // box model: read_active and data appear one cycle after read_enable
    always @(posedge clk) begin
        if (box_write_enable) mem[box_address] <= box_write_data;
        model_act <= box_read_enable && model_en;
        if (box_read_enable) model_rd <= mem[box_address];
    end
    assign box_read_active = model_act | stray;
    assign box_read_data   = model_rd;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [23:0] obs;
        rst = 1'b0;
        repeat (3) tick();
        obs = {cmd_ready, rsp_valid, rsp_data, rsp_error, busy, box_read_enable,
               box_write_enable, box_write_data, box_address};
        n_checks++;
        if (obs !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 24'h0);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: got {cmd_ready,busy}=%b expected 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_write;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_wdata = 8'hAA;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({box_write_enable, box_read_enable, box_address, box_write_data, cmd_ready, busy}
            !== {1'b1, 1'b0, 2'd0, 8'hAA, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL write_strobe: we=%b re=%b addr=%0d wd=%h rdy=%b busy=%b expected 1 0 0 aa 0 1",
                     box_write_enable, box_read_enable, box_address, box_write_data, cmd_ready, busy);
        end
        tick();
        n_checks++;
        if ({box_write_enable, rsp_valid, rsp_data, rsp_error} !== {1'b0, 1'b1, 8'hAA, 1'b0}) begin
            n_fail++;
            $display("FAIL write_rsp: we=%b valid=%b data=%h err=%b expected 0 1 aa 0",
                     box_write_enable, rsp_valid, rsp_data, rsp_error);
        end
        tick();
        n_checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL write_done: {valid,rdy,busy}=%b expected 010", {rsp_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_read;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd1; cmd_wdata = 8'h55;
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({box_read_enable, box_write_enable, box_address} !== {1'b1, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL read_strobe: re=%b we=%b addr=%0d expected 1 0 1",
                     box_read_enable, box_write_enable, box_address);
        end
        tick();
        n_checks++;
        if ({box_read_enable, rsp_valid, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL read_wait: {re,valid,busy}=%b expected 001", {box_read_enable, rsp_valid, busy});
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 8'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL read_rsp: valid=%b data=%h err=%b expected 1 55 0", rsp_valid, rsp_data, rsp_error);
        end
        tick();
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL read_done: {valid,rdy}=%b expected 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd2; cmd_wdata = 8'h11;
        tick();
        cmd_addr = 2'd3; cmd_wdata = 8'h22;
        n_checks++;
        if ({box_write_enable, box_address, box_write_data} !== {1'b1, 2'd2, 8'h11}) begin
            n_fail++;
            $display("FAIL b2b_wr1: we=%b addr=%0d wd=%h expected 1 2 11", box_write_enable, box_address, box_write_data);
        end
        tick();
        n_checks++;
        if ({box_write_enable, rsp_valid, cmd_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_rsp1: {we,valid,rdy}=%b expected 010", {box_write_enable, rsp_valid, cmd_ready});
        end
        tick();
        n_checks++;
        if ({rsp_valid, cmd_ready, box_write_enable} !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_idle: {valid,rdy,we}=%b expected 010", {rsp_valid, cmd_ready, box_write_enable});
        end
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({box_write_enable, box_address, box_write_data} !== {1'b1, 2'd3, 8'h22}) begin
            n_fail++;
            $display("FAIL b2b_wr2: we=%b addr=%0d wd=%h expected 1 3 22", box_write_enable, box_address, box_write_data);
        end
        repeat (2) tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2;
        tick();
        cmd_addr = 2'd3;
        repeat (2) tick();
        n_checks++;
        if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 8'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_rd1: valid=%b data=%h rdy=%b expected 1 11 0", rsp_valid, rsp_data, cmd_ready);
        end
        tick();
        n_checks++;
        if ({cmd_ready, box_read_enable} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_rd_idle: {rdy,re}=%b expected 10", {cmd_ready, box_read_enable});
        end
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({box_read_enable, box_address} !== {1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL b2b_rd2_strobe: re=%b addr=%0d expected 1 3", box_read_enable, box_address);
        end
        repeat (2) tick();
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 8'h22, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_rd2: valid=%b data=%h err=%b expected 1 22 0", rsp_valid, rsp_data, rsp_error);
        end
        tick();
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid, rsp_data, rsp_error, cmd_ready, box_read_enable, box_write_enable}
                !== {1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: valid=%b data=%h err=%b rdy=%b re=%b we=%b expected 1 aa 0 0 0 0",
                         i, rsp_valid, rsp_data, rsp_error, cmd_ready, box_read_enable, box_write_enable);
            end
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_release: {valid,rdy}=%b expected 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_stray;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        n_checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL stray_idle: {valid,busy,rdy}=%b expected 001", {rsp_valid, busy, cmd_ready});
        end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd3; cmd_wdata = 8'h5A;
        tick();
        cmd_valid = 1'b0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 8'h5A, 1'b0}) begin
            n_fail++;
            $display("FAIL stray_wr: valid=%b data=%h err=%b expected 1 5a 0", rsp_valid, rsp_data, rsp_error);
        end
        tick();
        n_checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL stray_wr_done: {valid,rdy,busy}=%b expected 010", {rsp_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_timeout;
        model_en = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1;
        tick();
        cmd_valid = 1'b0;
`ifdef BOX_INITIATOR_TIMEOUT_EN
        repeat (TO) tick();
        n_checks++;
        if ({rsp_valid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_early: {valid,busy}=%b expected 01", {rsp_valid, busy});
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 8'hFF, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_rsp: valid=%b data=%h err=%b expected 1 ff 1", rsp_valid, rsp_data, rsp_error);
        end
        tick();
`else
        repeat (40) tick();
        n_checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL wait_forever: {valid,busy,rdy}=%b expected 010", {rsp_valid, busy, cmd_ready});
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`endif
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic [23:0] obs;
        model_en = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        obs = {cmd_ready, rsp_valid, rsp_data, rsp_error, busy, box_read_enable,
               box_write_enable, box_write_data, box_address};
        n_checks++;
        if (obs !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected %h", obs, 24'h0);
        end
        rst = 1'b1;
        model_en = 1'b1;
        tick();
        n_checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_release: {rdy,busy}=%b expected 10", {cmd_ready, busy});
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1;
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 8'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_read: valid=%b data=%h err=%b expected 1 55 0", rsp_valid, rsp_data, rsp_error);
        end
        tick();
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_wdata = 8'h00;
        rsp_ready = 1'b1; stray = 1'b0; model_en = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_backpressure();
        test_stray();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
